// File: rtl/rns_9_8_7_pkg.sv
// Shared definitions for the {9, 8, 7} residue number system blocks:
// moduli, residue widths and the converter FSM state encoding.
package rns_9_8_7_pkg;

    localparam int MOD1    = 9;
    localparam int MOD2    = 8;
    localparam int MOD3    = 7;
    localparam int M_RANGE = MOD1 * MOD2 * MOD3;

    localparam int W1 = 4;
    localparam int W2 = 3;
    localparam int W3 = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rns_state_t;

endpackage

// File: rtl/rns_mod_step.sv
// One MSB-first Horner step of a modular reduction: (2*acc + b) mod MOD.
// acc is always < MOD, so 2*acc+b < 2*MOD and one conditional subtract suffices.
module rns_mod_step #(
    parameter int MOD = 9,
    parameter int W   = 4
) (
    input  logic [W-1:0] acc_i,
    input  logic         b_i,
    output logic [W-1:0] res_o
);

    localparam logic [W:0] MOD_V = (W+1)'(MOD);

    logic [W:0] t;

    assign t     = {acc_i, b_i};
    assign res_o = (t >= MOD_V) ? W'(t - MOD_V) : t[W-1:0];

endmodule

// File: rtl/rns_fwd_conv_9_8_7.sv
// Bit-serial binary-to-RNS forward converter for moduli {9, 8, 7}.
// Consumes the captured operand MSB first, one bit per clock, with valid/ready on both sides.
module rns_fwd_conv_9_8_7 #(
    parameter int X_WIDTH = 9,
    parameter int M_RANGE = 504
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [X_WIDTH-1:0] x_in,
    input  logic               valid_in,
    output logic               ready_out,
    output logic [3:0]         r1_out,
    output logic [2:0]         r2_out,
    output logic [2:0]         r3_out,
    output logic               range_err_out,
    output logic               valid_out,
    input  logic               ready_in
);
    import rns_9_8_7_pkg::*;

    localparam int                CNT_W     = $clog2(X_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(X_WIDTH - 1);
    localparam logic [X_WIDTH:0]  M_RANGE_V = (X_WIDTH+1)'(M_RANGE);

    rns_state_t         state_q, state_d;
    logic [X_WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W1-1:0]      a9_q, a9_d, a9_step, r1_q, r1_d;
    logic [W2-1:0]      a8_q, a8_d, a8_step, r2_q, r2_d;
    logic [W3-1:0]      a7_q, a7_d, a7_step, r3_q, r3_d;
    logic               rerr_q, rerr_d;
    logic               b;

    // The shift register moves the next bit to its MSB, so b is always x[cnt].
    assign b = sh_q[X_WIDTH-1];

    rns_mod_step #(.MOD(MOD1), .W(W1)) u_step9 (
        .acc_i (a9_q),
        .b_i   (b),
        .res_o (a9_step)
    );

    rns_mod_step #(.MOD(MOD3), .W(W3)) u_step7 (
        .acc_i (a7_q),
        .b_i   (b),
        .res_o (a7_step)
    );

    assign a8_step = {a8_q[W2-2:0], b};

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        a9_d    = a9_q;
        a8_d    = a8_q;
        a7_d    = a7_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        r3_d    = r3_q;
        rerr_d  = rerr_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    sh_d    = x_in;
                    cnt_d   = CNT_INIT;
                    a9_d    = '0;
                    a8_d    = '0;
                    a7_d    = '0;
                    rerr_d  = ({1'b0, x_in} >= M_RANGE_V);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sh_d = {sh_q[X_WIDTH-2:0], 1'b0};
                a9_d = a9_step;
                a8_d = a8_step;
                a7_d = a7_step;
                if (cnt_q == '0) begin
                    r1_d    = a9_step;
                    r2_d    = a8_step;
                    r3_d    = a7_step;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (ready_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            a9_q    <= '0;
            a8_q    <= '0;
            a7_q    <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            r3_q    <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            a9_q    <= a9_d;
            a8_q    <= a8_d;
            a7_q    <= a7_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            r3_q    <= r3_d;
            rerr_q  <= rerr_d;
        end
    end

    assign ready_out     = (state_q == IDLE);
    assign valid_out     = (state_q == DONE);
    assign r1_out        = r1_q;
    assign r2_out        = r2_q;
    assign r3_out        = r3_q;
    assign range_err_out = rerr_q;

endmodule

// File: tb/tb_rns_fwd_conv_9_8_7.sv
// Bench for the {9, 8, 7} forward converter: directed vectors, backpressure,
// mid-conversion reset, random operands and a full-range sweep against x mod m.
module tb_rns_fwd_conv_9_8_7;

    logic       clk_in   = 1'b0;
    logic       rst_in   = 1'b1;
    logic [8:0] x_in     = '0;
    logic       valid_in = 1'b0;
    logic       ready_in = 1'b0;
    logic       ready_out;
    logic [3:0] r1_out;
    logic [2:0] r2_out;
    logic [2:0] r3_out;
    logic       range_err_out;
    logic       valid_out;

    int total = 0;
    int bad   = 0;

    rns_fwd_conv_9_8_7 #(.X_WIDTH(9), .M_RANGE(504)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .x_in          (x_in),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .r1_out        (r1_out),
        .r2_out        (r2_out),
        .r3_out        (r3_out),
        .range_err_out (range_err_out),
        .valid_out     (valid_out),
        .ready_in      (ready_in)
    );

    always #5 clk_in = ~clk_in;

    // Reference: residues straight from integer arithmetic, packed {r1, r2, r3, err}.
    function automatic logic [10:0] model(input int x);
        logic [3:0] m9 = 4'(x % 9);
        logic [2:0] m8 = 3'(x % 8);
        logic [2:0] m7 = 3'(x % 7);
        return {m9, m8, m7, (x >= 504)};
    endfunction

    // Chinese-remainder decode by search; -1 if the triple is not a valid residue set.
    function automatic int crt_decode(input logic [3:0] a, input logic [2:0] b, input logic [2:0] c);
        for (int v = 0; v < 504; v++)
            if ((v % 9) == int'(a) && (v % 8) == int'(b) && (v % 7) == int'(c)) return v;
        return -1;
    endfunction

    // Drives one operand from an idle converter and waits for valid_out.
    // Called #1 after an edge; returns #1 after the edge where valid_out rose.
    task automatic run_op(input logic [8:0] x, output logic [10:0] got, output int lat);
        x_in     = x;
        valid_in = 1'b1;
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        x_in     = 9'($urandom);
        lat      = 0;
        while (!valid_out && lat < 40) begin
            @(posedge clk_in); #1;
            lat++;
        end
        got = {r1_out, r2_out, r3_out, range_err_out};
    endtask

    task automatic test_reset;
        #12;
        total++;
        if ({valid_out, r1_out, r2_out, r3_out, range_err_out} !== 12'd0) begin
            bad++;
            $display("FAIL reset_state: got valid/res/err=%b required all zero",
                     {valid_out, r1_out, r2_out, r3_out, range_err_out});
        end
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        total++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: got ready=%b valid=%b required ready=1 valid=0", ready_out, valid_out);
        end
    endtask

    task automatic test_directed;
        logic [8:0]  xs  [6] = '{9'd0, 9'd503, 9'd252, 9'd1, 9'd510, 9'd504};
        logic [10:0] exp [6] = '{{4'd0, 3'd0, 3'd0, 1'b0}, {4'd8, 3'd7, 3'd6, 1'b0},
                                 {4'd0, 3'd4, 3'd0, 1'b0}, {4'd1, 3'd1, 3'd1, 1'b0},
                                 {4'd6, 3'd6, 3'd6, 1'b1}, {4'd0, 3'd0, 3'd0, 1'b1}};
        logic [10:0] got;
        int lat;
        ready_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_op(xs[i], got, lat);
            total++;
            if (lat !== 9) begin
                bad++;
                $display("FAIL directed_latency x=%0d: got %0d edges required 9", xs[i], lat);
            end
            total++;
            if (got !== exp[i]) begin
                bad++;
                $display("FAIL directed_result x=%0d: got r1=%0d r2=%0d r3=%0d err=%0d required r1=%0d r2=%0d r3=%0d err=%0d",
                         xs[i], got[10:7], got[6:4], got[3:1], got[0], exp[i][10:7], exp[i][6:4], exp[i][3:1], exp[i][0]);
            end
            @(posedge clk_in); #1;
            total++;
            if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
                bad++;
                $display("FAIL directed_handoff x=%0d: got ready=%b valid=%b required ready=1 valid=0",
                         xs[i], ready_out, valid_out);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [8:0]  x = 9'($urandom_range(1, 511));
        logic [10:0] got;
        int lat;
        ready_in = 1'b0;
        run_op(x, got, lat);
        total++;
        if (lat !== 9 || got !== model(int'(x))) begin
            bad++;
            $display("FAIL bp_result x=%0d: got lat=%0d res=%h required lat=9 res=%h", x, lat, got, model(int'(x)));
        end
        for (int c = 0; c < 20; c++) begin
            x_in     = 9'($urandom);
            valid_in = 1'($urandom);
            @(posedge clk_in); #1;
            total++;
            if (valid_out !== 1'b1 || ready_out !== 1'b0 ||
                {r1_out, r2_out, r3_out, range_err_out} !== model(int'(x))) begin
                bad++;
                $display("FAIL bp_hold cycle=%0d: got valid=%b ready=%b res=%h required valid=1 ready=0 res=%h",
                         c, valid_out, ready_out, {r1_out, r2_out, r3_out, range_err_out}, model(int'(x)));
            end
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(posedge clk_in); #1;
        total++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: got valid=%b ready=%b required valid=0 ready=1", valid_out, ready_out);
        end
        @(posedge clk_in); #1;
        total++;
        if (valid_out !== 1'b0) begin
            bad++;
            $display("FAIL bp_single_transfer: got valid=%b required 0", valid_out);
        end
    endtask

    task automatic test_reset_mid;
        logic [10:0] got;
        int lat;
        ready_in = 1'b1;
        x_in     = 9'd503;
        valid_in = 1'b1;
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #3 rst_in = 1'b1;
        #1;
        total++;
        if ({valid_out, r1_out, r2_out, r3_out, range_err_out} !== 12'd0 || ready_out !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_async: got valid/res/err=%b ready=%b required zeros and ready=1",
                     {valid_out, r1_out, r2_out, r3_out, range_err_out}, ready_out);
        end
        @(posedge clk_in);
        #3 rst_in = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk_in); #1;
            total++;
            if (valid_out !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_no_partial cycle=%0d: got valid=%b required 0", c, valid_out);
            end
        end
        run_op(9'd100, got, lat);
        total++;
        if (lat !== 9 || got !== {4'd1, 3'd4, 3'd2, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset_next x=100: got lat=%0d res=%h required lat=9 res=%h",
                     lat, got, {4'd1, 3'd4, 3'd2, 1'b0});
        end
        @(posedge clk_in); #1;
    endtask

    task automatic test_random;
        logic [8:0]  x;
        logic [10:0] got;
        int lat;
        for (int i = 0; i < 40; i++) begin
            x        = 9'($urandom_range(0, 511));
            ready_in = 1'b0;
            run_op(x, got, lat);
            total++;
            if (lat !== 9 || got !== model(int'(x))) begin
                bad++;
                $display("FAIL random x=%0d: got lat=%0d res=%h required lat=9 res=%h", x, lat, got, model(int'(x)));
            end
            repeat ($urandom_range(0, 3)) @(posedge clk_in);
            #1 ready_in = 1'b1;
            @(posedge clk_in); #1;
        end
    endtask

    task automatic test_back_to_back;
        logic [10:0] got;
        int lat;
        int dec [504];
        int exp_cmp, got_cmp, self_cmp;
        ready_in = 1'b1;
        for (int x = 0; x < 504; x++) begin
            run_op(9'(x), got, lat);
            total++;
            if (lat !== 9 || got !== model(x)) begin
                bad++;
                $display("FAIL sweep x=%0d: got lat=%0d res=%h required lat=9 res=%h", x, lat, got, model(x));
            end
            dec[x] = crt_decode(got[10:7], got[6:4], got[3:1]);
            @(posedge clk_in); #1;
        end
        // Ordering as a comparator would see it: 2=gr, 1=eq, 0=le; x against itself must be eq.
        for (int x = 0; x < 504; x++) begin
            exp_cmp  = (x > 251) ? 2 : 0;
            got_cmp  = (dec[x] > dec[503-x]) ? 2 : ((dec[x] == dec[503-x]) ? 1 : 0);
            self_cmp = (dec[x] == x) ? 1 : ((dec[x] > x) ? 2 : 0);
            total++;
            if (got_cmp != exp_cmp || self_cmp != 1) begin
                bad++;
                $display("FAIL sweep_compare x=%0d: got pair=%0d self=%0d required pair=%0d self=1",
                         x, got_cmp, self_cmp, exp_cmp);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_backpressure;
        test_reset_mid;
        test_random;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
